// File: rtl/router_pkt_tx.sv
// Packet source for the 1x3 router: buffers host payload bytes, then emits
// header {len, addr}, payload (pkt_valid high) and an even-parity byte under busy back-pressure.
module router_pkt_tx #(
    parameter int unsigned MAX_LEN    = 63,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       tx_start,
    input  logic [1:0] tx_addr,
    input  logic       busy,
    output logic [7:0] data_out,
    output logic       pkt_valid,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_reject,
    output logic       wr_drop,
    output logic [5:0] buf_count
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] HEADER  = 3'd1;
    localparam logic [2:0] PAYLOAD = 3'd2;
    localparam logic [2:0] PARITY  = 3'd3;
    localparam logic [2:0] GAP     = 3'd4;

    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);
    localparam logic [5:0] MaxCount = 6'(MAX_LEN);

    logic [7:0] mem [MAX_LEN];

    logic [2:0]      state_q, state_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            done_q, done_d;
    logic            reject_q, reject_d;
    logic            drop_q, drop_d;
    logic [5:0]      count_q, count_d;
    logic [5:0]      rd_q, rd_d;
    logic [7:0]      parity_q, parity_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic            mem_we;
    logic [5:0]      cnt_eff;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        reject_d = 1'b0;
        drop_d   = 1'b0;
        count_d  = count_q;
        rd_d     = rd_q;
        parity_d = parity_q;
        gap_d    = gap_q;
        mem_we   = 1'b0;
        cnt_eff  = count_q;

        if (state_q != IDLE && wr_en) begin
            drop_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (wr_en) begin
                    if (count_q < MaxCount) begin
                        mem_we  = 1'b1;
                        count_d = count_q + 6'd1;
                        cnt_eff = count_q + 6'd1;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
                // A same-cycle write counts toward the header length.
                if (tx_start) begin
                    if (cnt_eff == 6'd0 || tx_addr == 2'd3) begin
                        reject_d = 1'b1;
                    end else begin
                        state_d  = HEADER;
                        data_d   = {cnt_eff, tx_addr};
                        valid_d  = 1'b1;
                        parity_d = 8'h00;
                        rd_d     = 6'd0;
                    end
                end
            end
            HEADER: begin
                if (!busy) begin
                    parity_d = parity_q ^ data_q;
                    data_d   = mem[0];
                    rd_d     = 6'd1;
                    state_d  = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (!busy) begin
                    parity_d = parity_q ^ data_q;
                    if (rd_q == count_q) begin
                        data_d  = parity_q ^ data_q;
                        valid_d = 1'b0;
                        state_d = PARITY;
                    end else begin
                        data_d = mem[rd_q];
                        rd_d   = rd_q + 6'd1;
                    end
                end
            end
            PARITY: begin
                if (!busy) begin
                    done_d  = 1'b1;
                    data_d  = 8'h00;
                    valid_d = 1'b0;
                    count_d = 6'd0;
                    rd_d    = 6'd0;
                    gap_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_q == GapLast) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= IDLE;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            reject_q <= 1'b0;
            drop_q   <= 1'b0;
            count_q  <= 6'd0;
            rd_q     <= 6'd0;
            parity_q <= 8'h00;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            reject_q <= reject_d;
            drop_q   <= drop_d;
            count_q  <= count_d;
            rd_q     <= rd_d;
            parity_q <= parity_d;
            gap_q    <= gap_d;
        end
    end

    // Payload RAM is never reset; only entries below buf_count are ever read.
    always_ff @(posedge clock) begin
        if (mem_we && resetn) begin
            mem[count_q] <= wr_data;
        end
    end

    assign data_out  = data_q;
    assign pkt_valid = valid_q;
    assign tx_busy   = (state_q != IDLE);
    assign tx_done   = done_q;
    assign tx_reject = reject_q;
    assign wr_drop   = drop_q;
    assign buf_count = count_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: directed scenarios plus randomized packets
// under random back-pressure, checked against a queue-based stream model.
module tb_router_pkt_tx;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       tx_start = 1'b0;
    logic [1:0] tx_addr = 2'd0;
    logic       busy = 1'b0;
    logic [7:0] data_out;
    logic       pkt_valid, tx_busy, tx_done, tx_reject, wr_drop;
    logic [5:0] buf_count;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] payload[$];
    logic [7:0] stream[$];

    router_pkt_tx #(.MAX_LEN(63), .GAP_CYCLES(2)) dut (
        .clock(clock), .resetn(resetn), .wr_en(wr_en), .wr_data(wr_data),
        .tx_start(tx_start), .tx_addr(tx_addr), .busy(busy), .data_out(data_out),
        .pkt_valid(pkt_valid), .tx_busy(tx_busy), .tx_done(tx_done),
        .tx_reject(tx_reject), .wr_drop(wr_drop), .buf_count(buf_count)
    );

    always #5 clock = ~clock;

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [7:0] b);
        wr_en = 1'b1;
        wr_data = b;
        cycle();
        wr_en = 1'b0;
    endtask

    task automatic start(input logic [1:0] a);
        tx_start = 1'b1;
        tx_addr = a;
        cycle();
        tx_start = 1'b0;
    endtask

    task automatic load(input int n, input bit ramp);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = ramp ? 8'(i) : 8'($urandom);
            payload.push_back(b);
            wr(b);
        end
    endtask

    // Expected wire stream: header {len, addr}, payload, then the byte that zeroes the XOR.
    task automatic build_stream(input logic [1:0] a);
        logic [7:0] hdr, par;
        stream.delete();
        hdr = {6'(payload.size()), a};
        par = hdr;
        stream.push_back(hdr);
        foreach (payload[i]) begin
            stream.push_back(payload[i]);
            par = par ^ payload[i];
        end
        stream.push_back(par);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        wr_en = 1'b0;
        tx_start = 1'b0;
        busy = 1'b0;
        cycle();
        resetn = 1'b1;
        payload.delete();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        wr_en = 1'b1;
        tx_start = 1'b1;
        cycle();
        cycle();
        wr_en = 1'b0;
        tx_start = 1'b0;
        vectors++;
        if (data_out !== 8'h00 || pkt_valid !== 1'b0 || tx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out: got data=%h valid=%b busy=%b want 00/0/0",
                     data_out, pkt_valid, tx_busy);
        end
        vectors++;
        if (tx_done !== 1'b0 || tx_reject !== 1'b0 || wr_drop !== 1'b0 || buf_count !== 6'd0) begin
            miscompares++;
            $display("FAIL reset_flags: got done=%b rej=%b drop=%b cnt=%0d want 0/0/0/0",
                     tx_done, tx_reject, wr_drop, buf_count);
        end
        resetn = 1'b1;
        cycle();
    endtask

    task automatic test_basic();
        logic [7:0] exp_d[5] = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        logic       exp_v[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        wr(8'h11); wr(8'h22); wr(8'h33);
        vectors++;
        if (buf_count !== 6'd3) begin
            miscompares++;
            $display("FAIL basic_count: got %0d want 3", buf_count);
        end
        start(2'd1);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (data_out !== exp_d[i] || pkt_valid !== exp_v[i] || tx_busy !== 1'b1) begin
                miscompares++;
                $display("FAIL basic_byte%0d: got %h/%b busy=%b want %h/%b busy=1",
                         i, data_out, pkt_valid, tx_busy, exp_d[i], exp_v[i]);
            end
            cycle();
        end
        vectors++;
        if (tx_done !== 1'b1 || buf_count !== 6'd0 || data_out !== 8'h00 || tx_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_done: got done=%b cnt=%0d data=%h busy=%b want 1/0/00/1",
                     tx_done, buf_count, data_out, tx_busy);
        end
        cycle();
        vectors++;
        if (tx_done !== 1'b0 || tx_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_gap2: got done=%b busy=%b want 0/1", tx_done, tx_busy);
        end
        cycle();
        vectors++;
        if (tx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_idle: got busy=%b want 0", tx_busy);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_d[7] = '{8'h0D, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22, 8'h33};
        wr(8'h11); wr(8'h22); wr(8'h33);
        start(2'd1);
        for (int i = 0; i < 7; i++) begin
            vectors++;
            if (data_out !== exp_d[i] || pkt_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_byte%0d: got %h/%b want %h/1", i, data_out, pkt_valid, exp_d[i]);
            end
            busy = (i >= 2 && i <= 4);
            cycle();
        end
        busy = 1'b0;
        vectors++;
        if (data_out !== 8'h0D || pkt_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_parity: got %h/%b want 0d/0", data_out, pkt_valid);
        end
        cycle();
        vectors++;
        if (tx_done !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_done: got %b want 1", tx_done);
        end
        cycle();
        cycle();
    endtask

    task automatic test_rejects();
        start(2'd0);
        vectors++;
        if (tx_reject !== 1'b1 || tx_busy !== 1'b0 || pkt_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rej_empty: got rej=%b busy=%b valid=%b want 1/0/0",
                     tx_reject, tx_busy, pkt_valid);
        end
        cycle();
        vectors++;
        if (tx_reject !== 1'b0) begin
            miscompares++;
            $display("FAIL rej_pulse: got %b want 0", tx_reject);
        end
        wr(8'hAA);
        start(2'd3);
        vectors++;
        if (tx_reject !== 1'b1 || buf_count !== 6'd1 || pkt_valid !== 1'b0 || tx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rej_addr3: got rej=%b cnt=%0d valid=%b busy=%b want 1/1/0/0",
                     tx_reject, buf_count, pkt_valid, tx_busy);
        end
        cycle();
        vectors++;
        if (pkt_valid !== 1'b0 || buf_count !== 6'd1) begin
            miscompares++;
            $display("FAIL rej_after: got valid=%b cnt=%0d want 0/1", pkt_valid, buf_count);
        end
        do_reset();
    endtask

    task automatic test_full();
        payload.delete();
        load(63, 1'b1);
        vectors++;
        if (wr_drop !== 1'b0 || buf_count !== 6'd63) begin
            miscompares++;
            $display("FAIL full_63: got drop=%b cnt=%0d want 0/63", wr_drop, buf_count);
        end
        wr(8'h3F);
        vectors++;
        if (wr_drop !== 1'b1 || buf_count !== 6'd63) begin
            miscompares++;
            $display("FAIL full_drop: got drop=%b cnt=%0d want 1/63", wr_drop, buf_count);
        end
        build_stream(2'd2);
        start(2'd2);
        for (int i = 0; i < stream.size(); i++) begin
            vectors++;
            if (data_out !== stream[i] || pkt_valid !== 1'(i < stream.size() - 1)) begin
                miscompares++;
                $display("FAIL full_byte%0d: got %h/%b want %h", i, data_out, pkt_valid, stream[i]);
            end
            cycle();
        end
        vectors++;
        if (tx_done !== 1'b1 || buf_count !== 6'd0) begin
            miscompares++;
            $display("FAIL full_done: got done=%b cnt=%0d want 1/0", tx_done, buf_count);
        end
        cycle();
        cycle();
    endtask

    task automatic test_reset_mid();
        payload.delete();
        load(4, 1'b0);
        start(2'd0);
        cycle();
        cycle();
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
        vectors++;
        if (pkt_valid !== 1'b0 || data_out !== 8'h00 || buf_count !== 6'd0 ||
            tx_busy !== 1'b0 || tx_done !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_state: got valid=%b data=%h cnt=%0d busy=%b done=%b want all 0",
                     pkt_valid, data_out, buf_count, tx_busy, tx_done);
        end
        cycle();
        vectors++;
        if (tx_done !== 1'b0 || pkt_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_quiet: got done=%b valid=%b want 0/0", tx_done, pkt_valid);
        end
        payload.delete();
        load(2, 1'b0);
        build_stream(2'd1);
        start(2'd1);
        for (int i = 0; i < stream.size(); i++) begin
            vectors++;
            if (data_out !== stream[i] || pkt_valid !== 1'(i < stream.size() - 1)) begin
                miscompares++;
                $display("FAIL rstmid_byte%0d: got %h/%b want %h", i, data_out, pkt_valid, stream[i]);
            end
            cycle();
        end
        vectors++;
        if (tx_done !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_done: got %b want 1", tx_done);
        end
        cycle();
        cycle();
    endtask

    task automatic test_gap_ignored();
        payload.delete();
        load(3, 1'b0);
        build_stream(2'd1);
        start(2'd1);
        for (int i = 0; i < stream.size(); i++) begin
            vectors++;
            if (data_out !== stream[i] || pkt_valid !== 1'(i < stream.size() - 1)) begin
                miscompares++;
                $display("FAIL gap_byte%0d: got %h/%b want %h", i, data_out, pkt_valid, stream[i]);
            end
            wr_en = (i == 1);
            tx_start = (i == 1);
            tx_addr = 2'd0;
            cycle();
            wr_en = 1'b0;
            tx_start = 1'b0;
            if (i == 1) begin
                vectors++;
                if (wr_drop !== 1'b1 || tx_reject !== 1'b0) begin
                    miscompares++;
                    $display("FAIL gap_pay_in: got drop=%b rej=%b want 1/0", wr_drop, tx_reject);
                end
            end
        end
        vectors++;
        if (tx_done !== 1'b1) begin
            miscompares++;
            $display("FAIL gap_done: got %b want 1", tx_done);
        end
        wr(8'h99);
        vectors++;
        if (wr_drop !== 1'b1 || buf_count !== 6'd0 || tx_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL gap_wr: got drop=%b cnt=%0d busy=%b want 1/0/1", wr_drop, buf_count, tx_busy);
        end
        start(2'd1);
        vectors++;
        if (tx_reject !== 1'b0 || tx_busy !== 1'b0 || pkt_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL gap_last_start: got rej=%b busy=%b valid=%b want 0/0/0",
                     tx_reject, tx_busy, pkt_valid);
        end
        wr(8'h77);
        start(2'd2);
        vectors++;
        if (data_out !== 8'h06 || pkt_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL gap_idle_start: got %h/%b want 06/1", data_out, pkt_valid);
        end
        cycle();
        cycle();
        vectors++;
        if (data_out !== 8'h71 || pkt_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL gap_idle_parity: got %h/%b want 71/0", data_out, pkt_valid);
        end
        cycle();
        cycle();
        cycle();
    endtask

    task automatic test_random();
        int n, idx, guard;
        logic [1:0] a;
        bit b;
        for (int pk = 0; pk < 20; pk++) begin
            payload.delete();
            n = $urandom_range(1, (pk % 5 == 0) ? 63 : 10);
            load(n, 1'b0);
            a = 2'($urandom_range(0, 2));
            build_stream(a);
            start(a);
            idx = 0;
            guard = 0;
            while (idx < stream.size() && guard < 400) begin
                vectors++;
                if (data_out !== stream[idx] || pkt_valid !== 1'(idx < stream.size() - 1) ||
                    tx_done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rand_p%0d_b%0d: got %h/%b done=%b want %h",
                             pk, idx, data_out, pkt_valid, tx_done, stream[idx]);
                end
                b = ($urandom_range(0, 3) == 0);
                busy = b;
                cycle();
                if (!b) idx++;
                guard++;
            end
            busy = 1'b0;
            vectors++;
            if (guard >= 400 || tx_done !== 1'b1 || buf_count !== 6'd0) begin
                miscompares++;
                $display("FAIL rand_p%0d_done: got done=%b cnt=%0d guard=%0d want 1/0",
                         pk, tx_done, buf_count, guard);
            end
            cycle();
            cycle();
            vectors++;
            if (tx_busy !== 1'b0) begin
                miscompares++;
                $display("FAIL rand_p%0d_idle: got busy=%b want 0", pk, tx_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_rejects();
        test_full();
        test_reset_mid();
        test_gap_ignored();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
- Packet source for the router input port. It drives the same byte-stream protocol the router input register stage consumes.
- A host loads up to MAX_LEN payload bytes into an internal buffer, then issues a start with a destination address.
- The block then emits three things in order:
  - a header byte `{len[5:0], addr[1:0]}`;
  - the payload bytes, with `pkt_valid` high;
  - an even-parity byte, with `pkt_valid` low.
- It honours router `busy` back-pressure throughout. It serves as the upstream traffic generator or bridge in the 1x3 router subsystem and its testbenches.

Parameters:
- MAX_LEN, 63, payload buffer depth in bytes; legal range 1..63 (6-bit length field).
- GAP_CYCLES, 2, idle cycles forced after each parity byte before the next start is accepted; must be >= 1.

Ports:
- clock  input  1  single clock; all logic on rising edge.
- resetn  input  1  synchronous, active-low reset.
- wr_en  input  1  host payload write strobe.
- wr_data  input  8  payload byte to append to buffer.
- tx_start  input  1  one-cycle request to send the buffered packet.
- tx_addr  input  2  destination port 0..2; 3 is illegal.
- busy  input  1  router back-pressure; while high, the byte on data_out is not consumed.
- data_out  output  8  byte to router data_in.
- pkt_valid  output  1  high for header and payload bytes, low for parity byte and idle.
- tx_busy  output  1  high in any state other than IDLE.
- tx_done  output  1  one-cycle pulse when the parity byte is accepted.
- tx_reject  output  1  one-cycle pulse when tx_start is refused.
- wr_drop  output  1  one-cycle pulse when a write is discarded.
- buf_count  output  6  bytes currently buffered.

Behaviour:
- Reset (resetn low at an edge): state=IDLE; data_out=0; pkt_valid=0; tx_done=tx_reject=wr_drop=0; buf_count=0; rd pointer=0; parity accumulator=0. Buffer RAM contents are don't-care. Reset mid-packet aborts the packet at once, with pkt_valid=0 on the next cycle and no tx_done.
- Byte acceptance rule: the byte on data_out is transferred at a rising edge when state is HEADER, PAYLOAD or PARITY and busy=0. While busy=1, data_out, pkt_valid, pointers and parity all hold.
- Registered outputs only; no combinational path from inputs to data_out or pkt_valid.
- IDLE:
  - wr_en with buf_count<MAX_LEN writes buffer[buf_count] and increments buf_count.
  - wr_en with buf_count==MAX_LEN raises wr_drop for 1 cycle; the buffer is unchanged.
  - tx_start with buf_count==0 or tx_addr==3 raises tx_reject for 1 cycle and stays in IDLE; the buffer is retained.
  - A valid tx_start latches addr and goes to HEADER. On the next cycle: data_out={buf_count,addr}, pkt_valid=1, parity=0.
  - wr_en and tx_start in the same cycle: the write is performed first, and the header length includes that byte.
- HEADER, on accept:
  - parity ^= header;
  - data_out=buffer[0]; rd=1;
  - next state PAYLOAD.
- PAYLOAD, on accept:
  - parity ^= data_out.
  - If rd==buf_count: data_out=parity^data_out (the final XOR), pkt_valid=0, next state PARITY.
  - Otherwise: data_out=buffer[rd], rd++.
  - pkt_valid stays high continuously through the payload, including busy stalls.
- PARITY, on accept:
  - tx_done pulses 1 cycle;
  - data_out=0, pkt_valid=0;
  - buf_count=0, rd=0;
  - next state GAP.
- GAP: counts exactly GAP_CYCLES cycles, then returns to IDLE.
- Outside IDLE:
  - wr_en is discarded with a wr_drop pulse.
  - tx_start is ignored silently, with no reject.
- Latency: header appears 1 cycle after tx_start. With busy=0 throughout, a packet of N payload bytes occupies N+2 consecutive cycles. tx_done is asserted in the cycle after the parity byte is accepted.
- Parity is the XOR of the header and all payload bytes, so the XOR of all transmitted bytes including parity is 0x00.
- buf_count arithmetic is 6-bit; it never wraps because writes are blocked at MAX_LEN.
- tx_busy = (state != IDLE).

Test Plan:
- Basic packet: write 0x11,0x22,0x33; tx_start, addr=1; busy=0 → data_out 0x0D,0x11,0x22,0x33 with pkt_valid=1, then 0x0D with pkt_valid=0. tx_done pulses the next cycle, buf_count=0, and IDLE is reached after 2 GAP cycles.
- Back-pressure: same packet; hold busy=1 for 3 cycles while 0x22 is on data_out → 0x22 and pkt_valid=1 held for 4 cycles total, stream unchanged, parity still 0x0D.
- Rejects: tx_start with empty buffer → tx_reject pulse. Write 0xAA, then tx_start with addr=3 → tx_reject pulse, buf_count remains 1, pkt_valid never rises.
- Full buffer: write 64 bytes 0x00..0x3F → 64th write gives a wr_drop pulse and buf_count=63. tx_start with addr=2 gives header 0xFE, then 0x00..0x3E, then parity = 0xFE ^ XOR(0x00..0x3E).
- Reset mid-packet: assert resetn=0 during the payload → next cycle pkt_valid=0, data_out=0, buf_count=0, tx_busy=0, no tx_done. A subsequent packet is sent correctly.
- Gap and ignored inputs: tx_start and wr_en during PAYLOAD and GAP → tx_start ignored, wr_drop pulses, current packet unaffected. A tx_start in the last GAP cycle is ignored; one issued in IDLE is accepted.
